// File: rtl/p405s_exe_gprwrctl_if.sv
// Bus between the execute/load writeback sources, the read-address source and the
// GPR write controller. The controller (slave) drives the array-facing outputs.
interface p405s_exe_gprwrctl_if;
   // Load handshake: a load transfers on any cycle where ldWbVal and ldWbRdy are both 1.
   // ldWbRdy never depends on ldWbVal. Execute writebacks have no ready and always transfer.
   logic        exeWbVal;
   logic [0:4]  exeWbAddr;
   logic [0:31] exeWbData;
   logic        ldWbVal;
   logic [0:4]  ldWbAddr;
   logic [0:31] ldWbData;
   logic        ldWbRdy;
   logic [0:4]  rdAAddr;
   logic [0:4]  rdBAddr;
   logic [0:4]  rdSAddr;
   logic        RpWE;
   logic [0:4]  RpAddr;
   logic [0:31] rPort;
   logic        LpWE;
   logic [0:4]  LpAddr;
   logic [0:31] lPort;
   logic [0:9]  ApAddr;
   logic [0:9]  BpAddr;
   logic [0:9]  SpAddr;
   logic        LpEqAp;
   logic        LpEqBp;
   logic        LpEqSp;
   logic        RpEqAp;
   logic        RpEqBp;
   logic        RpEqSp;
   logic        BpEqSp;
   logic [1:0]  dbg_q_count;

   modport master (
      output exeWbVal, exeWbAddr, exeWbData, ldWbVal, ldWbAddr, ldWbData,
             rdAAddr, rdBAddr, rdSAddr,
      input  ldWbRdy, RpWE, RpAddr, rPort, LpWE, LpAddr, lPort,
             ApAddr, BpAddr, SpAddr, LpEqAp, LpEqBp, LpEqSp,
             RpEqAp, RpEqBp, RpEqSp, BpEqSp, dbg_q_count
   );

   modport slave (
      input  exeWbVal, exeWbAddr, exeWbData, ldWbVal, ldWbAddr, ldWbData,
             rdAAddr, rdBAddr, rdSAddr,
      output ldWbRdy, RpWE, RpAddr, rPort, LpWE, LpAddr, lPort,
             ApAddr, BpAddr, SpAddr, LpEqAp, LpEqBp, LpEqSp,
             RpEqAp, RpEqBp, RpEqSp, BpEqSp, dbg_q_count
   );
endinterface

// File: rtl/p405s_exe_gprwrctl.sv
// GPR write-side controller: merges execute and queued load writebacks onto the R/L
// write ports and registers predecoded read addresses plus write-through bypass flags.
module p405s_exe_gprwrctl (
   input logic                 SysClk,
   input logic                 SysRst_n,
   p405s_exe_gprwrctl_if.slave wr
);

   // Load queue, slot 0 is the head; entries stay packed toward slot 0.
   logic        q_val  [0:1];
   logic        q_kill [0:1];
   logic [0:4]  q_addr [0:1];
   logic [0:31] q_data [0:1];
   logic        n_val  [0:1];
   logic        n_kill [0:1];
   logic [0:4]  n_addr [0:1];
   logic [0:31] n_data [0:1];
   logic [1:0]  q_cnt;
   logic        ld_rdy;
   logic        push;
   logic        pop;
   logic        wr_idx;

   logic        lp_we_nxt;
   logic [0:4]  lp_addr_nxt;
   logic [0:31] lp_data_nxt;
   logic [0:4]  rp_addr_nxt;
   logic [0:31] rp_data_nxt;

   logic        lp_we_q, rp_we_q;
   logic [0:4]  lp_addr_q, rp_addr_q;
   logic [0:31] lp_data_q, rp_data_q;
   logic [0:9]  ap_q, bp_q, sp_q;
   logic        lp_eq_a_q, lp_eq_b_q, lp_eq_s_q;
   logic        rp_eq_a_q, rp_eq_b_q, rp_eq_s_q, bp_eq_s_q;

   function automatic logic [0:9] predecode(input logic [0:4] a);
      logic [0:9] p;
      p[0:1] = a[0] ? 2'b01 : 2'b10;
      p[2:5] = 4'b1000 >> a[1:2];
      p[6:9] = 4'b1000 >> a[3:4];
      return p;
   endfunction

   assign q_cnt  = {q_val[0] & q_val[1], q_val[0] ^ q_val[1]};
   assign ld_rdy = (q_cnt != 2'd2);
   assign push   = wr.ldWbVal & ld_rdy;
   assign pop    = q_val[0];

   // A head that matches this cycle's execute target is older data and is dropped.
   always_comb begin
      lp_we_nxt   = q_val[0] & ~q_kill[0] & ~(wr.exeWbVal & (q_addr[0] == wr.exeWbAddr));
      lp_addr_nxt = lp_we_nxt ? q_addr[0] : lp_addr_q;
      lp_data_nxt = lp_we_nxt ? q_data[0] : lp_data_q;
      rp_addr_nxt = wr.exeWbVal ? wr.exeWbAddr : rp_addr_q;
      rp_data_nxt = wr.exeWbVal ? wr.exeWbData : rp_data_q;
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         n_val[i]  = q_val[i];
         n_kill[i] = q_kill[i] | (wr.exeWbVal & q_val[i] & (q_addr[i] == wr.exeWbAddr));
         n_addr[i] = q_addr[i];
         n_data[i] = q_data[i];
      end
      if (pop) begin
         n_val[0]  = n_val[1];
         n_kill[0] = n_kill[1];
         n_addr[0] = n_addr[1];
         n_data[0] = n_data[1];
         n_val[1]  = 1'b0;
         n_kill[1] = 1'b0;
      end
      wr_idx = n_val[0];
      if (push) begin
         n_val[wr_idx]  = 1'b1;
         n_kill[wr_idx] = wr.exeWbVal & (wr.ldWbAddr == wr.exeWbAddr);
         n_addr[wr_idx] = wr.ldWbAddr;
         n_data[wr_idx] = wr.ldWbData;
      end
   end

   always_ff @(posedge SysClk or negedge SysRst_n) begin
      if (!SysRst_n) begin
         for (int i = 0; i < 2; i++) begin
            q_val[i]  <= 1'b0;
            q_kill[i] <= 1'b0;
            q_addr[i] <= '0;
            q_data[i] <= '0;
         end
         lp_we_q   <= 1'b0;
         rp_we_q   <= 1'b0;
         lp_addr_q <= '0;
         rp_addr_q <= '0;
         lp_data_q <= '0;
         rp_data_q <= '0;
         ap_q      <= 10'h288;
         bp_q      <= 10'h288;
         sp_q      <= 10'h288;
         lp_eq_a_q <= 1'b0;
         lp_eq_b_q <= 1'b0;
         lp_eq_s_q <= 1'b0;
         rp_eq_a_q <= 1'b0;
         rp_eq_b_q <= 1'b0;
         rp_eq_s_q <= 1'b0;
         bp_eq_s_q <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            q_val[i]  <= n_val[i];
            q_kill[i] <= n_kill[i];
            q_addr[i] <= n_addr[i];
            q_data[i] <= n_data[i];
         end
         lp_we_q   <= lp_we_nxt;
         rp_we_q   <= wr.exeWbVal;
         lp_addr_q <= lp_addr_nxt;
         rp_addr_q <= rp_addr_nxt;
         lp_data_q <= lp_data_nxt;
         rp_data_q <= rp_data_nxt;
         ap_q      <= predecode(wr.rdAAddr);
         bp_q      <= predecode(wr.rdBAddr);
         sp_q      <= predecode(wr.rdSAddr);
         lp_eq_a_q <= lp_we_nxt & (lp_addr_nxt == wr.rdAAddr);
         lp_eq_b_q <= lp_we_nxt & (lp_addr_nxt == wr.rdBAddr);
         lp_eq_s_q <= lp_we_nxt & (lp_addr_nxt == wr.rdSAddr);
         rp_eq_a_q <= wr.exeWbVal & (rp_addr_nxt == wr.rdAAddr);
         rp_eq_b_q <= wr.exeWbVal & (rp_addr_nxt == wr.rdBAddr);
         rp_eq_s_q <= wr.exeWbVal & (rp_addr_nxt == wr.rdSAddr);
         bp_eq_s_q <= (wr.rdBAddr == wr.rdSAddr);
      end
   end

   assign wr.ldWbRdy     = ld_rdy;
   assign wr.dbg_q_count = q_cnt;
   assign wr.RpWE        = rp_we_q;
   assign wr.RpAddr      = rp_addr_q;
   assign wr.rPort       = rp_data_q;
   assign wr.LpWE        = lp_we_q;
   assign wr.LpAddr      = lp_addr_q;
   assign wr.lPort       = lp_data_q;
   assign wr.ApAddr      = ap_q;
   assign wr.BpAddr      = bp_q;
   assign wr.SpAddr      = sp_q;
   assign wr.LpEqAp      = lp_eq_a_q;
   assign wr.LpEqBp      = lp_eq_b_q;
   assign wr.LpEqSp      = lp_eq_s_q;
   assign wr.RpEqAp      = rp_eq_a_q;
   assign wr.RpEqBp      = rp_eq_b_q;
   assign wr.RpEqSp      = rp_eq_s_q;
   assign wr.BpEqSp      = bp_eq_s_q;

endmodule

// File: tb/tb_p405s_exe_gprwrctl.sv
// Bench for the GPR write controller: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based reference model through an expected-value queue.
module tb_p405s_exe_gprwrctl;

   logic SysClk   = 1'b0;
   logic SysRst_n = 1'b1;

   p405s_exe_gprwrctl_if bus ();

   p405s_exe_gprwrctl dut (
      .SysClk   (SysClk),
      .SysRst_n (SysRst_n),
      .wr       (bus)
   );

   always #5 SysClk = ~SysClk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          kill;
   } ld_t;

   typedef struct packed {
      logic        rdy;
      logic [1:0]  cnt;
      logic        rp_we;
      logic [4:0]  rp_addr;
      logic [31:0] rp_data;
      logic        lp_we;
      logic [4:0]  lp_addr;
      logic [31:0] lp_data;
      logic [9:0]  ap;
      logic [9:0]  bp;
      logic [9:0]  sp;
      logic [6:0]  flags;
   } exp_t;

   localparam int W = $bits(exp_t);

   logic [W-1:0] exp_q[$];
   ld_t          mq[$];
   logic [4:0]   m_rp_addr, m_lp_addr;
   logic [31:0]  m_rp_data, m_lp_data;
   int           chk_cnt  = 0;
   int           pass_cnt = 0;
   bit           in_reset = 1'b1;
   bit           running  = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // Predecoded form: one hot bit per field, fields are a[0], a[1:2], a[3:4] MSB first.
   function automatic logic [9:0] pd_ref(input logic [4:0] a);
      logic [9:0] p;
      int hi, mid, lo;
      hi  = int'(a[4]);
      mid = int'(a[3:2]);
      lo  = int'(a[1:0]);
      p = '0;
      p[9 - hi]  = 1'b1;
      p[7 - mid] = 1'b1;
      p[3 - lo]  = 1'b1;
      return p;
   endfunction

   task automatic model_step(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                             input bit lv, input logic [4:0] la, input logic [31:0] ld,
                             input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rs);
      exp_t e;
      ld_t  h;
      bit   rdy_pre;
      bit   lwe;
      rdy_pre = (mq.size() < 2);
      lwe = 1'b0;
      if (mq.size() > 0) begin
         h = mq.pop_front();
         lwe = !h.kill && !(ev && h.addr == ea);
         if (lwe) begin
            m_lp_addr = h.addr;
            m_lp_data = h.data;
         end
      end
      if (lv && rdy_pre) begin
         h.addr = la;
         h.data = ld;
         h.kill = 1'b0;
         mq.push_back(h);
      end
      if (ev) begin
         foreach (mq[i]) if (mq[i].addr == ea) mq[i].kill = 1'b1;
         m_rp_addr = ea;
         m_rp_data = ed;
      end
      e.rdy     = (mq.size() < 2);
      e.cnt     = 2'(mq.size());
      e.rp_we   = ev;
      e.rp_addr = m_rp_addr;
      e.rp_data = m_rp_data;
      e.lp_we   = lwe;
      e.lp_addr = m_lp_addr;
      e.lp_data = m_lp_data;
      e.ap      = pd_ref(ra);
      e.bp      = pd_ref(rb);
      e.sp      = pd_ref(rs);
      e.flags   = {lwe && m_lp_addr == ra, lwe && m_lp_addr == rb, lwe && m_lp_addr == rs,
                   ev && m_rp_addr == ra, ev && m_rp_addr == rb, ev && m_rp_addr == rs,
                   rb == rs};
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rs);
      @(negedge SysClk);
      bus.exeWbVal  = ev;
      bus.exeWbAddr = ea;
      bus.exeWbData = ed;
      bus.ldWbVal   = lv;
      bus.ldWbAddr  = la;
      bus.ldWbData  = ld;
      bus.rdAAddr   = ra;
      bus.rdBAddr   = rb;
      bus.rdSAddr   = rs;
      model_step(ev, ea, ed, lv, la, ld, ra, rb, rs);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
   endtask

   task automatic rand_cycle();
      logic [4:0] ra, rb, rs;
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? rb : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom(), ra, rb, rs);
   endtask

   task automatic zero_inputs();
      bus.exeWbVal  = 1'b0;
      bus.exeWbAddr = '0;
      bus.exeWbData = '0;
      bus.ldWbVal   = 1'b0;
      bus.ldWbAddr  = '0;
      bus.ldWbData  = '0;
      bus.rdAAddr   = '0;
      bus.rdBAddr   = '0;
      bus.rdSAddr   = '0;
   endtask

   task automatic apply_reset();
      @(negedge SysClk);
      in_reset = 1'b1;
      zero_inputs();
      #2 SysRst_n = 1'b0;
      #1;
      check("rst_ldWbRdy", 64'(bus.ldWbRdy), 64'd1);
      check("rst_q_count", 64'(bus.dbg_q_count), 64'd0);
      check("rst_we", 64'({bus.LpWE, bus.RpWE}), 64'd0);
      check("rst_addr", 64'({bus.LpAddr, bus.RpAddr}), 64'd0);
      check("rst_lPort", 64'(bus.lPort), 64'd0);
      check("rst_rPort", 64'(bus.rPort), 64'd0);
      check("rst_ApAddr", 64'(bus.ApAddr), 64'h288);
      check("rst_BpAddr", 64'(bus.BpAddr), 64'h288);
      check("rst_SpAddr", 64'(bus.SpAddr), 64'h288);
      check("rst_flags", 64'({bus.LpEqAp, bus.LpEqBp, bus.LpEqSp, bus.RpEqAp, bus.RpEqBp,
                              bus.RpEqSp, bus.BpEqSp}), 64'd0);
      mq.delete();
      exp_q.delete();
      m_rp_addr = '0;
      m_lp_addr = '0;
      m_rp_data = '0;
      m_lp_data = '0;
      repeat (2) @(negedge SysClk);
      @(posedge SysClk);
      #2 SysRst_n = 1'b1;
      in_reset = 1'b0;
   endtask

   // Monitor: every clock outside reset the DUT presents one set of outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge SysClk);
         #1;
         if (running && !in_reset && SysRst_n) begin
            if (exp_q.size() == 0) begin
               check("exp_q_underflow", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("ldWbRdy", 64'(bus.ldWbRdy), 64'(e.rdy));
               check("q_count", 64'(bus.dbg_q_count), 64'(e.cnt));
               check("RpWE", 64'(bus.RpWE), 64'(e.rp_we));
               check("RpAddr", 64'(bus.RpAddr), 64'(e.rp_addr));
               check("rPort", 64'(bus.rPort), 64'(e.rp_data));
               check("LpWE", 64'(bus.LpWE), 64'(e.lp_we));
               if (e.lp_we) begin
                  check("LpAddr", 64'(bus.LpAddr), 64'(e.lp_addr));
                  check("lPort", 64'(bus.lPort), 64'(e.lp_data));
               end
               check("ApAddr", 64'(bus.ApAddr), 64'(e.ap));
               check("BpAddr", 64'(bus.BpAddr), 64'(e.bp));
               check("SpAddr", 64'(bus.SpAddr), 64'(e.sp));
               check("eq_flags", 64'({bus.LpEqAp, bus.LpEqBp, bus.LpEqSp, bus.RpEqAp,
                                      bus.RpEqBp, bus.RpEqSp, bus.BpEqSp}), 64'(e.flags));
            end
         end
      end
   end

   initial begin
      zero_inputs();
      apply_reset();
      // execute write with matching A read
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
      // back-to-back loads
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_1111, 5'd1, 5'd2, 5'd3);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_2222, 5'd1, 5'd2, 5'd3);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_3333, 5'd1, 5'd2, 5'd3);
      repeat (3) idle();
      // head load collides with same-cycle execute write
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_0007, 5'd7, 5'd0, 5'd0);
      drive(1'b1, 5'd7, 32'hE7E7_E7E7, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd0);
      repeat (2) idle();
      // younger load killed while pushed, older head still written
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0009, 5'd9, 5'd10, 5'd0);
      drive(1'b1, 5'd10, 32'hA0A0_A0A0, 1'b1, 5'd10, 32'hBAD0_0010, 5'd9, 5'd10, 5'd10);
      repeat (3) idle();
      // predecode extremes and B/S equality
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd31, 5'd31);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd31, 5'd12);
      repeat (300) rand_cycle();
      // reset with loads in flight
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd6, 5'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0066, 5'd4, 5'd6, 5'd0);
      apply_reset();
      repeat (3) idle();
      repeat (200) rand_cycle();
      idle();
      @(posedge SysClk);
      #2 running = 1'b0;
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
